// File: rtl/shift_reg_prog.sv
// Programmable-length shift register / delay line with a runtime output tap,
// per-stage valids, rotate, parallel load and synchronous flush.
module shift_reg_prog #(
  parameter  int N  = 4,
  parameter  int M  = 4,
  localparam int LW = $clog2(M + 1)
) (
  input  logic            Clk,
  input  logic            Clr_n,
  input  logic [1:0]      Mode,
  input  logic            Flush,
  input  logic [LW-1:0]   Len,
  input  logic [N-1:0]    SI,
  input  logic            SIValid,
  input  logic [N*M-1:0]  PI,
  output logic [N-1:0]    SO,
  output logic            SOValid,
  output logic [LW-1:0]   Occ,
  output logic [N*M-1:0]  PO
);

  localparam logic [LW-1:0] MAX_LEN = LW'(M);

  logic [N-1:0]  stage [M];
  logic [M-1:0]  vld;
  logic [LW-1:0] len_eff;
  logic [LW-1:0] tap;

  always_comb begin
    len_eff = Len;
    if (Len == '0)
      len_eff = LW'(1);
    else if (Len > MAX_LEN)
      len_eff = MAX_LEN;
  end

  assign tap = len_eff - LW'(1);

  // Tap select doubles as the rotate feedback path
  always_comb begin
    SO      = '0;
    SOValid = 1'b0;
    Occ     = '0;
    PO      = '0;
    for (int i = 0; i < M; i++) begin
      PO[i*N +: N] = stage[i];
      if (LW'(i) == tap) begin
        SO      = stage[i];
        SOValid = vld[i];
      end
      if (LW'(i) < len_eff)
        Occ = Occ + LW'(vld[i]);
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      for (int i = 0; i < M; i++)
        stage[i] <= '0;
      vld <= '0;
    end else if (Flush) begin
      for (int i = 0; i < M; i++)
        stage[i] <= '0;
      vld <= '0;
    end else begin
      unique case (Mode)
        2'b00: ;
        2'b01: begin
          stage[0] <= SI;
          vld[0]   <= SIValid;
          for (int i = 1; i < M; i++) begin
            stage[i] <= stage[i-1];
            vld[i]   <= vld[i-1];
          end
        end
        2'b10: begin
          stage[0] <= SO;
          vld[0]   <= SOValid;
          for (int i = 1; i < M; i++) begin
            stage[i] <= stage[i-1];
            vld[i]   <= vld[i-1];
          end
        end
        2'b11: begin
          for (int i = 0; i < M; i++)
            stage[i] <= PI[i*N +: N];
          vld <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_prog.sv
// Bench for shift_reg_prog: vector table with expected-result queue,
// plus hand sequences for async reset and the M=1 build.
module tb_shift_reg_prog;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [1:0]  mode;
  logic        flush;
  logic [2:0]  len;
  logic [3:0]  si;
  logic        sivld;
  logic [15:0] pi;
  logic [3:0]  so;
  logic        sov;
  logic [2:0]  occ;
  logic [15:0] po;

  logic [1:0]  mode1;
  logic        flush1;
  logic [0:0]  len1;
  logic [3:0]  si1;
  logic        sivld1;
  logic [3:0]  pi1;
  logic [3:0]  so1;
  logic        sov1;
  logic [0:0]  occ1;
  logic [3:0]  po1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_reg_prog #(.N(4), .M(4)) dut (
    .Clk(clk), .Clr_n(clr_n), .Mode(mode), .Flush(flush),
    .Len(len), .SI(si), .SIValid(sivld), .PI(pi),
    .SO(so), .SOValid(sov), .Occ(occ), .PO(po)
  );

  shift_reg_prog #(.N(4), .M(1)) dut1 (
    .Clk(clk), .Clr_n(clr_n), .Mode(mode1), .Flush(flush1),
    .Len(len1), .SI(si1), .SIValid(sivld1), .PI(pi1),
    .SO(so1), .SOValid(sov1), .Occ(occ1), .PO(po1)
  );

  always @(posedge clk)
    if (clr_n === 1'b1 && $isunknown(mode)) begin
      n_fail++;
      $display("FAIL mode_x: Mode=%b at edge, required known", mode);
    end

  typedef struct {
    string       nm;
    logic        fl;
    logic [1:0]  md;
    logic [2:0]  ln;
    logic [3:0]  si;
    logic        sv;
    logic [15:0] pi;
    logic [3:0]  so;
    logic        sov;
    logic [2:0]  occ;
    logic [15:0] po;
  } vec_t;

  typedef struct {
    string       nm;
    logic [3:0]  so;
    logic        sov;
    logic [2:0]  occ;
    logic [15:0] po;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(string nm, logic fl, logic [1:0] md,
                              logic [2:0] ln, logic [3:0] s, logic sv,
                              logic [15:0] p, logic [3:0] eso,
                              logic esov, logic [2:0] eocc,
                              logic [15:0] epo);
    vec_t v;
    v.nm = nm; v.fl = fl; v.md = md; v.ln = ln; v.si = s;
    v.sv = sv; v.pi = p; v.so = eso; v.sov = esov;
    v.occ = eocc; v.po = epo;
    return v;
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    clr_n = 1'b0; mode = 2'b00; flush = 1'b0; len = 3'd4;
    si = '0; sivld = 1'b0; pi = '0;
    mode1 = 2'b00; flush1 = 1'b0; len1 = 1'b1;
    si1 = '0; sivld1 = 1'b0; pi1 = '0;

    vecs.push_back(mk("sh1",  0, 2'b01, 4, 4'h1, 1, 16'h0, 4'h0, 0, 1, 16'h0001));
    vecs.push_back(mk("sh2",  0, 2'b01, 4, 4'h2, 1, 16'h0, 4'h0, 0, 2, 16'h0012));
    vecs.push_back(mk("sh3",  0, 2'b01, 4, 4'h3, 1, 16'h0, 4'h0, 0, 3, 16'h0123));
    vecs.push_back(mk("sh4",  0, 2'b01, 4, 4'h4, 1, 16'h0, 4'h1, 1, 4, 16'h1234));
    vecs.push_back(mk("fl0",  1, 2'b00, 2, 4'h0, 0, 16'h0, 4'h0, 0, 0, 16'h0000));
    vecs.push_back(mk("sha",  0, 2'b01, 2, 4'hA, 1, 16'h0, 4'h0, 0, 1, 16'h000A));
    vecs.push_back(mk("shb",  0, 2'b01, 2, 4'hB, 1, 16'h0, 4'hA, 1, 2, 16'h00AB));
    vecs.push_back(mk("len0", 0, 2'b00, 0, 4'h0, 0, 16'h0, 4'hB, 1, 1, 16'h00AB));
    vecs.push_back(mk("len7", 0, 2'b00, 7, 4'h0, 0, 16'h0, 4'h0, 0, 2, 16'h00AB));
    vecs.push_back(mk("ld",   0, 2'b11, 3, 4'h0, 0, 16'hDCBA, 4'hC, 1, 3, 16'hDCBA));
    vecs.push_back(mk("rot1", 0, 2'b10, 3, 4'hF, 1, 16'h0, 4'hB, 1, 3, 16'hCBAC));
    vecs.push_back(mk("rot2", 0, 2'b10, 3, 4'hF, 0, 16'h0, 4'hA, 1, 3, 16'hBACB));
    vecs.push_back(mk("rot3", 0, 2'b10, 3, 4'hF, 1, 16'h0, 4'hC, 1, 3, 16'hACBA));
    vecs.push_back(mk("s5",   0, 2'b01, 3, 4'h5, 1, 16'h0, 4'hB, 1, 3, 16'hCBA5));
    vecs.push_back(mk("s6",   0, 2'b01, 3, 4'h6, 0, 16'h0, 4'hA, 1, 2, 16'hBA56));
    vecs.push_back(mk("s7",   0, 2'b01, 3, 4'h7, 1, 16'h0, 4'h5, 1, 2, 16'hA567));
    vecs.push_back(mk("s8",   0, 2'b01, 3, 4'h8, 1, 16'h0, 4'h6, 0, 2, 16'h5678));
    vecs.push_back(mk("ld2",  0, 2'b11, 4, 4'h0, 0, 16'h1357, 4'h1, 1, 4, 16'h1357));
    vecs.push_back(mk("flld", 1, 2'b11, 4, 4'hF, 1, 16'hFFFF, 4'h0, 0, 0, 16'h0000));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk("hold", 0, 2'b00, 4, 4'hF, 1, 16'hFFFF, 4'h0, 0, 0, 16'h0000));

    #3;
    check("rst_so", 16'(so), 16'h0);
    check("rst_sov", 16'(sov), 16'h0);
    check("rst_occ", 16'(occ), 16'h0);
    check("rst_po", po, 16'h0);
    #9 clr_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      flush = vecs[i].fl; mode = vecs[i].md; len = vecs[i].ln;
      si = vecs[i].si; sivld = vecs[i].sv; pi = vecs[i].pi;
      sb.push_back('{vecs[i].nm, vecs[i].so, vecs[i].sov,
                     vecs[i].occ, vecs[i].po});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_empty: got 0 entries required 1");
      end else begin
        e = sb.pop_front();
        check({e.nm, "_so"}, 16'(so), 16'(e.so));
        check({e.nm, "_sov"}, 16'(sov), 16'(e.sov));
        check({e.nm, "_occ"}, 16'(occ), 16'(e.occ));
        check({e.nm, "_po"}, po, e.po);
      end
    end

    @(negedge clk);
    flush = 1'b0; mode = 2'b01; len = 3'd2; si = 4'h1; sivld = 1'b1;
    @(negedge clk);
    si = 4'h2;
    @(posedge clk);
    #1;
    check("pre_rst_so", 16'(so), 16'h1);
    check("pre_rst_occ", 16'(occ), 16'h2);
    @(negedge clk);
    mode = 2'b00;
    #1 clr_n = 1'b0;
    #1;
    check("mid_rst_so", 16'(so), 16'h0);
    check("mid_rst_sov", 16'(sov), 16'h0);
    check("mid_rst_occ", 16'(occ), 16'h0);
    check("mid_rst_po", po, 16'h0);
    #1 clr_n = 1'b1;
    mode = 2'b01; len = 3'd1; si = 4'h9; sivld = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_so", 16'(so), 16'h9);
    check("post_rst_occ", 16'(occ), 16'h1);
    check("post_rst_po", po, 16'h0009);
    @(negedge clk);
    mode = 2'b00;

    mode1 = 2'b01; si1 = 4'h9; sivld1 = 1'b1; len1 = 1'b1;
    @(posedge clk);
    #1;
    check("m1_sh_so", 16'(so1), 16'h9);
    check("m1_sh_sov", 16'(sov1), 16'h1);
    check("m1_sh_occ", 16'(occ1), 16'h1);
    check("m1_sh_po", 16'(po1), 16'h9);
    @(negedge clk);
    mode1 = 2'b10; si1 = 4'h3; sivld1 = 1'b0; len1 = 1'b0;
    @(posedge clk);
    #1;
    check("m1_rot_so", 16'(so1), 16'h9);
    check("m1_rot_sov", 16'(sov1), 16'h1);
    @(negedge clk);
    mode1 = 2'b11; pi1 = 4'h6;
    @(posedge clk);
    #1;
    check("m1_ld_so", 16'(so1), 16'h6);
    @(negedge clk);
    flush1 = 1'b1; pi1 = 4'hF;
    @(posedge clk);
    #1;
    check("m1_fl_so", 16'(so1), 16'h0);
    check("m1_fl_occ", 16'(occ1), 16'h0);
    @(negedge clk);
    flush1 = 1'b0; mode1 = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
